// File: rtl/local_ni_packetizer.sv
// Network-interface packetizer: turns a core message descriptor plus payload words
// into head/body/tail (or single) flits written into one router local-port VC buffer.
module local_ni_packetizer (
  input  logic         clk1,
  input  logic         reset,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [7:0]   msg_dest,
  input  logic [2:0]   msg_len,
  input  logic [1:0]   msg_vc,
  input  logic         pay_valid,
  output logic         pay_ready,
  input  logic [99:0]  pay_data,
  input  logic [2:0]   em_pl_t1,
  input  logic [2:0]   em_pl_t2,
  input  logic [2:0]   em_pl_t3,
  input  logic [2:0]   em_pl_t4,
  output logic         wr_en_t,
  output logic [127:0] bf_in_t,
  output logic         busy,
  output logic [2:0]   pkt_id
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state;
  logic [7:0]  dest_q;
  logic [2:0]  len_q;
  logic [1:0]  vc_q;
  logic [2:0]  idx_q;
  logic        credit_ok;
  logic        last_flit;
  logic [2:0]  flit_type;

  // Credit is taken from the VC latched at acceptance so it cannot change mid-packet.
  always_comb begin
    credit_ok = 1'b0;
    case (vc_q)
      2'd0: credit_ok = (em_pl_t1 != '0);
      2'd1: credit_ok = (em_pl_t2 != '0);
      2'd2: credit_ok = (em_pl_t3 != '0);
      2'd3: credit_ok = (em_pl_t4 != '0);
      default: credit_ok = 1'b0;
    endcase
  end

  assign msg_ready = (state == IDLE);
  assign busy      = (state == SEND);
  // Blocking right after a write leaves one cycle for the router's em_pl update.
  assign pay_ready = (state == SEND) && credit_ok && !wr_en_t;
  assign last_flit = (idx_q == len_q);

  always_comb begin
    flit_type = 3'b000;
    if (len_q == 3'd0)
      flit_type = 3'b010;
    else if (idx_q == 3'd0)
      flit_type = 3'b111;
    else if (last_flit)
      flit_type = 3'b001;
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      dest_q  <= '0;
      len_q   <= '0;
      vc_q    <= '0;
      idx_q   <= '0;
      pkt_id  <= '0;
      wr_en_t <= 1'b0;
      bf_in_t <= '0;
    end else begin
      wr_en_t <= 1'b0;
      case (state)
        IDLE: begin
          if (msg_valid) begin
            dest_q <= msg_dest;
            len_q  <= msg_len;
            vc_q   <= msg_vc;
            idx_q  <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (pay_valid && pay_ready) begin
            wr_en_t <= 1'b1;
            bf_in_t <= {flit_type, 1'b0, vc_q, 8'h00, dest_q, pay_data, idx_q, pkt_id};
            idx_q   <= idx_q + 3'd1;
            if (last_flit) begin
              state  <= IDLE;
              pkt_id <= pkt_id + 3'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_local_ni_packetizer.sv
// Bench for local_ni_packetizer: table of single-flit messages, directed multi-cycle
// sequences, and a randomized run against a queue-based packet model.
module tb_local_ni_packetizer;

  logic         clk1 = 1'b0;
  logic         reset;
  logic         msg_valid;
  logic         msg_ready;
  logic [7:0]   msg_dest;
  logic [2:0]   msg_len;
  logic [1:0]   msg_vc;
  logic         pay_valid;
  logic         pay_ready;
  logic [99:0]  pay_data;
  logic [2:0]   em_pl_t1, em_pl_t2, em_pl_t3, em_pl_t4;
  logic         wr_en_t;
  logic [127:0] bf_in_t;
  logic         busy;
  logic [2:0]   pkt_id;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk1 = ~clk1;

  local_ni_packetizer dut (
    .clk1      (clk1),
    .reset     (reset),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_dest  (msg_dest),
    .msg_len   (msg_len),
    .msg_vc    (msg_vc),
    .pay_valid (pay_valid),
    .pay_ready (pay_ready),
    .pay_data  (pay_data),
    .em_pl_t1  (em_pl_t1),
    .em_pl_t2  (em_pl_t2),
    .em_pl_t3  (em_pl_t3),
    .em_pl_t4  (em_pl_t4),
    .wr_en_t   (wr_en_t),
    .bf_in_t   (bf_in_t),
    .busy      (busy),
    .pkt_id    (pkt_id)
  );

  typedef struct {
    logic [7:0]  dest;
    logic [1:0]  vc;
    logic [99:0] pay;
    logic [5:0]  exp_top;
    logic [5:0]  exp_low;
    logic [2:0]  exp_next;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic set_em(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
    em_pl_t1 = a; em_pl_t2 = b; em_pl_t3 = c; em_pl_t4 = d;
  endtask

  task automatic do_reset();
    @(negedge clk1);
    reset = 1'b0; msg_valid = 1'b0; pay_valid = 1'b0;
    #1;
    check("rst_wr_en",     wr_en_t,   0);
    check("rst_bf_in",     bf_in_t,   0);
    check("rst_busy",      busy,      0);
    check("rst_msg_ready", msg_ready, 1);
    check("rst_pay_ready", pay_ready, 0);
    check("rst_pkt_id",    pkt_id,    0);
    @(negedge clk1);
    reset = 1'b1;
  endtask

  task automatic wait_write(input string name, output logic [127:0] f);
    bit got = 0;
    f = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk1);
      if (wr_en_t) begin got = 1; f = bf_in_t; end
    end
    n_total++;
    if (got) n_pass++;
    else $display("FAIL %s: got no write, required one within 40 cycles", name);
  endtask

  // Present a descriptor at a negedge; it is accepted on the following posedge.
  task automatic start_msg(input logic [7:0] d, input logic [2:0] l, input logic [1:0] v);
    @(negedge clk1);
    msg_valid = 1'b1; msg_dest = d; msg_len = l; msg_vc = v;
    @(negedge clk1);
    msg_valid = 1'b0;
  endtask

  // Reference model state
  logic [127:0] m_q [$];
  logic [127:0] m_flit;
  logic         m_wr;
  logic [2:0]   m_pkt;
  logic [1:0]   m_vc;

  function automatic logic [2:0] em_of(input logic [1:0] v);
    case (v)
      2'd0: return em_pl_t1;
      2'd1: return em_pl_t2;
      2'd2: return em_pl_t3;
      default: return em_pl_t4;
    endcase
  endfunction

  initial begin
    logic [127:0] f;
    logic [127:0] r;
    logic [2:0]   typ;
    logic [2:0]   exp_types [5];
    int           wcyc [5];
    int           nw;
    int           bad_ready;
    logic         exp_pr;

    reset = 1'b0; msg_valid = 1'b0; pay_valid = 1'b0;
    msg_dest = '0; msg_len = '0; msg_vc = '0; pay_data = '0;
    set_em(3'd7, 3'd7, 3'd7, 3'd7);

    tbl[0] = '{8'h9F, 2'd0, 100'h1E,          6'b010000, 6'd0, 3'd1};
    tbl[1] = '{8'h01, 2'd1, 100'h5,           6'b010001, 6'd1, 3'd2};
    tbl[2] = '{8'hFF, 2'd2, {100{1'b1}},      6'b010010, 6'd2, 3'd3};
    tbl[3] = '{8'h80, 2'd3, {1'b1, 98'd0, 1'b1}, 6'b010011, 6'd3, 3'd4};
    tbl[4] = '{8'h42, 2'd0, 100'hABCDE,       6'b010000, 6'd4, 3'd5};
    tbl[5] = '{8'h7E, 2'd1, 100'h123456789,   6'b010001, 6'd5, 3'd6};
    tbl[6] = '{8'h00, 2'd2, 100'h0,           6'b010010, 6'd6, 3'd7};
    tbl[7] = '{8'hC3, 2'd3, 100'h3C3C3C,      6'b010011, 6'd7, 3'd0};
    tbl[8] = '{8'h9F, 2'd0, 100'hFACE,        6'b010000, 6'd0, 3'd1};

    do_reset();

    // Single-flit table; only the selected VC has credit, covering wrap 0..7,0.
    for (int unsigned i = 0; i < 9; i++) begin
      set_em(tbl[i].vc == 2'd0 ? 3'd3 : 3'd0, tbl[i].vc == 2'd1 ? 3'd3 : 3'd0,
             tbl[i].vc == 2'd2 ? 3'd3 : 3'd0, tbl[i].vc == 2'd3 ? 3'd3 : 3'd0);
      pay_valid = 1'b1; pay_data = tbl[i].pay;
      start_msg(tbl[i].dest, 3'd0, tbl[i].vc);
      wait_write($sformatf("tbl%0d_write", i), f);
      check($sformatf("tbl%0d_top", i),  f[127:122], tbl[i].exp_top);
      check($sformatf("tbl%0d_zero", i), f[121:114], 0);
      check($sformatf("tbl%0d_dest", i), f[113:106], tbl[i].dest);
      check($sformatf("tbl%0d_pay", i),  f[105:6],   tbl[i].pay);
      check($sformatf("tbl%0d_low", i),  f[5:0],     tbl[i].exp_low);
      check($sformatf("tbl%0d_busy", i), busy,       0);
      check($sformatf("tbl%0d_pkt", i),  pkt_id,     tbl[i].exp_next);
      pay_valid = 1'b0;
    end

    // Five-flit packet on VC3 with payload always available.
    do_reset();
    set_em(3'd7, 3'd7, 3'd7, 3'd7);
    exp_types = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b001};
    pay_valid = 1'b1; pay_data = 100'h5A5;
    start_msg(8'h3C, 3'd4, 2'd2);
    nw = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk1);
      if (wr_en_t) begin
        if (nw < 5) begin
          check($sformatf("five_type%0d", nw), bf_in_t[127:125], exp_types[nw]);
          check($sformatf("five_vc%0d", nw),   bf_in_t[124:122], 3'b010);
          check($sformatf("five_idx%0d", nw),  bf_in_t[5:3],     nw);
          check($sformatf("five_pkt%0d", nw),  bf_in_t[2:0],     0);
          wcyc[nw] = c;
        end
        nw++;
      end
    end
    check("five_count", nw, 5);
    check("five_first_latency", wcyc[0], 0);
    for (int k = 1; k < 5; k++) check($sformatf("five_gap%0d", k), wcyc[k] - wcyc[k-1], 2);
    pay_valid = 1'b0;

    // Credit stall after the second flit.
    do_reset();
    set_em(3'd7, 3'd7, 3'd7, 3'd7);
    pay_valid = 1'b1;
    start_msg(8'h11, 3'd4, 2'd2);
    wait_write("stall_w0", f);
    wait_write("stall_w1", f);
    em_pl_t3 = 3'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk1);
      #1;
      check($sformatf("stall_wr%0d", c), wr_en_t, 0);
      check($sformatf("stall_pr%0d", c), pay_ready, 0);
      check($sformatf("stall_busy%0d", c), busy, 1);
    end
    em_pl_t3 = 3'd1;
    #1;
    check("stall_release_pr", pay_ready, 1);
    @(negedge clk1);
    check("stall_release_wr", wr_en_t, 1);
    check("stall_release_idx", bf_in_t[5:3], 2);
    wait_write("stall_w3", f);
    wait_write("stall_w4", f);
    check("stall_tail_type", f[127:125], 3'b001);
    pay_valid = 1'b0;

    // Descriptor held during SEND is ignored, then taken after the tail.
    do_reset();
    set_em(3'd7, 3'd7, 3'd7, 3'd7);
    pay_valid = 1'b1;
    @(negedge clk1);
    msg_valid = 1'b1; msg_dest = 8'h21; msg_len = 3'd2; msg_vc = 2'd1;
    @(negedge clk1);
    msg_dest = 8'h55; msg_len = 3'd0; msg_vc = 2'd3;
    nw = 0; bad_ready = 0;
    for (int c = 0; c < 30 && nw < 4; c++) begin
      if (nw < 3 && !wr_en_t && msg_ready) bad_ready++;
      @(negedge clk1);
      if (wr_en_t) begin
        if (nw < 3) begin
          check($sformatf("ign_dest%0d", nw), bf_in_t[113:106], 8'h21);
          check($sformatf("ign_vc%0d", nw),   bf_in_t[124:122], 3'b001);
          check($sformatf("ign_pkt%0d", nw),  bf_in_t[2:0],     0);
        end else begin
          check("ign_next_type", bf_in_t[127:122], 6'b010011);
          check("ign_next_dest", bf_in_t[113:106], 8'h55);
          check("ign_next_pkt",  bf_in_t[2:0],     1);
          msg_valid = 1'b0;
        end
        nw++;
      end
    end
    msg_valid = 1'b0;
    check("ign_ready_low_in_send", bad_ready, 0);
    check("ign_write_count", nw, 4);
    repeat (4) @(negedge clk1);
    check("ign_pkt_after", pkt_id, 2);
    check("ign_idle", busy, 0);
    pay_valid = 1'b0;

    // Reset in the middle of an 8-flit packet.
    do_reset();
    set_em(3'd7, 3'd7, 3'd7, 3'd7);
    pay_valid = 1'b1;
    start_msg(8'h01, 3'd0, 2'd0);
    wait_write("mid_pre", f);
    start_msg(8'h77, 3'd7, 2'd0);
    wait_write("mid_w0", f);
    wait_write("mid_w1", f);
    check("mid_w1_pkt", f[2:0], 1);
    reset = 1'b0;
    #1;
    check("mid_wr_en",     wr_en_t,   0);
    check("mid_msg_ready", msg_ready, 1);
    check("mid_pkt_id",    pkt_id,    0);
    check("mid_busy",      busy,      0);
    @(negedge clk1);
    reset = 1'b1;
    start_msg(8'h99, 3'd1, 2'd0);
    wait_write("mid_after", f);
    check("mid_after_type", f[127:125], 3'b111);
    check("mid_after_low",  f[5:0],     6'd0);
    check("mid_after_dest", f[113:106], 8'h99);
    wait_write("mid_after_tail", f);
    pay_valid = 1'b0;

    // Randomized run against the packet-queue model.
    do_reset();
    m_q.delete(); m_flit = '0; m_wr = 1'b0; m_pkt = '0; m_vc = '0;
    for (int unsigned cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk1);
      check("rnd_wr_en",     wr_en_t,   m_wr);
      check("rnd_bf_in",     bf_in_t,   m_flit);
      check("rnd_busy",      busy,      m_q.size() != 0);
      check("rnd_msg_ready", msg_ready, m_q.size() == 0);
      check("rnd_pkt_id",    pkt_id,    m_pkt);
      msg_valid = ($urandom_range(0, 2) == 0);
      msg_dest  = 8'($urandom);
      msg_len   = 3'($urandom);
      msg_vc    = 2'($urandom);
      pay_valid = ($urandom_range(0, 3) != 0);
      r = {$urandom, $urandom, $urandom, $urandom};
      pay_data  = r[99:0];
      em_pl_t1  = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      em_pl_t2  = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      em_pl_t3  = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      em_pl_t4  = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      #1;
      exp_pr = (m_q.size() != 0) && (em_of(m_vc) != 3'd0) && !m_wr;
      check("rnd_pay_ready", pay_ready, exp_pr);
      if (m_q.size() == 0) begin
        m_wr = 1'b0;
        if (msg_valid) begin
          m_vc = msg_vc;
          for (int unsigned i = 0; i <= msg_len; i++) begin
            if (msg_len == 3'd0)      typ = 3'b010;
            else if (i == 0)          typ = 3'b111;
            else if (i == msg_len)    typ = 3'b001;
            else                      typ = 3'b000;
            m_q.push_back({typ, 1'b0, msg_vc, 8'h00, msg_dest, 100'd0, 3'(i), m_pkt});
          end
        end
      end else if (pay_valid && exp_pr) begin
        f = m_q.pop_front();
        f[105:6] = pay_data;
        m_flit = f;
        m_wr = 1'b1;
        if (m_q.size() == 0) m_pkt = m_pkt + 3'd1;
      end else begin
        m_wr = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/local_ni_packetizer.md
LOCAL_NI_PACKETIZER -- requirements
Module: local_ni_packetizer

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk1  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- msg_valid  in  1  core presents a new message descriptor.
- msg_ready  out  1  descriptor accepted when msg_valid and msg_ready are both 1 at a clk1 edge.
- msg_dest  in  8  destination router address.
- msg_len  in  3  flit count minus one (0 gives 1 flit, 7 gives 8 flits).
- msg_vc  in  2  target VC of the router local port (0..3 select VC1..VC4).
- pay_valid  in  1  payload word available.
- pay_ready  out  1  payload word consumed at this edge.
- pay_data  in  100  flit payload.
- em_pl_t1..em_pl_t4  in  3 each  empty-slot counts of local-port VC1..VC4 from the router.
- wr_en_t  out  1  write strobe into the router local-port buffer.
- bf_in_t  out  128  flit into the router local-port buffer.
- busy  out  1  packet in progress.
- pkt_id  out  3  id of the next or current packet.

REQ-002 The flit format SHALL be: [127:125] type (111 head, 000 body, 001 tail, 010 single); [124:122] {1'b0,vc}; [121:114] 8'b0; [113:106] dest; [105:6] payload; [5:3] flit index; [2:0] pkt_id.

Function
REQ-003 The FSM SHALL have states IDLE and SEND.
REQ-004 msg_ready SHALL be 1 exactly when the state is IDLE.
REQ-005 On descriptor acceptance, the block SHALL latch dest, len and vc, clear the flit index, and go to SEND.
REQ-006 credit_ok SHALL be 1 when the selected em_pl_tN is nonzero.
REQ-007 pay_ready SHALL be combinational and equal to (state SEND) AND credit_ok AND NOT wr_en_t.
- This enforces at least one idle cycle between writes, to cover the one-cycle em_pl refresh latency.
REQ-008 On an edge where pay_valid and pay_ready are both 1, the block SHALL register wr_en_t=1 and a bf_in_t flit built per REQ-002 with the current index. On all other edges it SHALL register wr_en_t=0 and hold bf_in_t.
REQ-009 Flit type SHALL follow the index:
- len=0: single.
- index 0: head.
- index equal to len: tail.
- otherwise: body.
REQ-010 After each flit the index SHALL increment. After the tail or single flit the FSM SHALL return to IDLE, and pkt_id SHALL increment modulo 8 (7 wraps to 0).
REQ-011 Latency SHALL be: descriptor accepted at edge k, then the first wr_en_t is high at the earliest from edge k+1. Minimum packet time is 2*(len+1) cycles.
REQ-012 While credit_ok=0 or pay_valid=0, the FSM SHALL stall in SEND with wr_en_t=0 and no state change.
REQ-013 msg_valid asserted while busy SHALL be ignored; the descriptor is not accepted.
REQ-014 busy SHALL be 1 exactly when the state is SEND.
REQ-015 Descriptor inputs SHALL be sampled only at acceptance; later changes do not affect the packet in flight.
REQ-016 The VC field and credit select SHALL stay fixed for the whole packet.

Reset
REQ-017 While reset=0 the block SHALL hold: state IDLE, wr_en_t=0, bf_in_t=0, index=0, pkt_id=0, busy=0.
- Resulting combinational outputs: msg_ready=1, pay_ready=0.
REQ-018 Reset asserted mid-packet SHALL abandon the packet with no tail emitted. The first descriptor after reset release SHALL carry pkt_id 0.

Verification
REQ-019 Single flit: len=0, dest=8'h9F, vc=0, em_pl_t1=7, payload 100'h1E -> exactly one write with bf_in_t[127:122]=6'b010000, [113:106]=8'h9F, [5:0]=0; busy falls after it; pkt_id=1.
REQ-020 Five-flit packet: len=4, vc=2, em_pl_t3=7, pay_valid held high -> writes on alternate cycles with types 111,000,000,000,001 and indices 0..4; [124:122]=3'b010 on every flit.
REQ-021 Credit stall: em_pl_t3 forced to 0 after the second flit -> wr_en_t and pay_ready stay 0; em_pl_t3 restored to 1 -> third flit is written one edge later.
REQ-022 Busy ignore: second msg_valid pulse during SEND -> msg_ready=0 and no extra packet; after the tail, the held msg_valid is accepted with the next pkt_id.
REQ-023 Wrap: nine back-to-back single-flit messages -> bf_in_t[2:0] sequence 0..7,0.
REQ-024 Reset mid-packet: reset=0 after the second flit of an 8-flit packet -> wr_en_t=0 immediately, msg_ready=1, pkt_id=0; the next packet starts at index 0 with a head flit.
